reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port integer register file with write-to-read bypass and a per-register pending-write scoreboard, for the riscv_core decode/writeback boundary. Registers clear on reset. Reads are combinational. One synchronous write port retires results. The scoreboard marks registers with an in-flight producer so decode can stall on RAW hazards without external tracking.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥2.
- `NRD`, 2, number of read ports, 1..4.
- `ZERO_REG`, 1, when 1, index 0 is hardwired: reads 0, ignores writes, never busy.
- `IDX_W`, derived `$clog2(NREGS)`, index width; not overridden.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `r_indx` in `NRD*IDX_W`: read indices, port k at bits `[k*IDX_W +: IDX_W]`.
- `r_data` out `NRD*XLEN`: read data, port k at `[k*XLEN +: XLEN]`.
- `r_busy` out `NRD`: bit k is 1 if the register on port k has a pending write.
- `w_en` in 1: write strobe.
- `w_indx` in `IDX_W`: write index.
- `w_data` in `XLEN`: write data.
- `sb_set_en` in 1: mark a register pending (instruction issued with destination).
- `sb_set_indx` in `IDX_W`: register to mark.
- `busy_vec` out `NREGS`: full scoreboard state, for debug and flush logic.
- `sb_flush` in 1: clear all pending bits (pipeline flush).

## Operation
- Reset (`rst_n`=0, asynchronous): all registers go to 0 and all busy bits go to 0. `r_data` reads 0 and `r_busy`/`busy_vec` read 0 while reset is held.
- **Write:** on a rising edge with `w_en`=1, `mem[w_indx]` ← `w_data`. Suppressed when `ZERO_REG`=1 and `w_indx`=0.
- **Read:** `r_data[k]` is combinational.
  - Port index 0 with `ZERO_REG`=1: data is 0.
  - `w_en`=1 and `w_indx`==`r_indx[k]` (and not the suppressed x0 case): bypass, data is `w_data` in the same cycle.
  - Otherwise: data is `mem[r_indx[k]]`.
- **`r_busy[k]`:** `busy[r_indx[k]]` AND NOT (`w_en` AND `w_indx`==`r_indx[k]`). A retiring write both un-busies and bypasses in that same cycle.
- **Scoreboard update, per clock edge, per register i:**
  - `sb_flush`=1: `busy[i]` ← 0, except i==`sb_set_indx` with `sb_set_en`=1, which is set to 1 (the issuing instruction survives the flush).
  - Else `sb_set_en`=1 and i==`sb_set_indx`: `busy[i]` ← 1. Set beats a clear from `w_en` to the same index, because the new producer supersedes.
  - Else `w_en`=1 and i==`w_indx`: `busy[i]` ← 0.
  - Index 0 with `ZERO_REG`=1 is never set.
- Writes to non-busy registers are legal and update data. Setting an already-busy register keeps it at 1; there is no counting.
- Out-of-range indices cannot occur, because `NREGS` is a power of two.

## Timing
- Read latency 0: combinational from `r_indx`, `w_en`, `w_indx`, `w_data`.
- Write latency 1: visible through the array on the cycle after the edge, and through bypass in the same cycle.
- Scoreboard set latency 1: `r_busy` rises the cycle after `sb_set_en`.
- Scoreboard clear: `r_busy` falls combinationally in the `w_en` cycle, and the stored bit is 0 after the edge.
- Reset deassertion: synchronous release is the integrator's job. The first write is accepted on the first edge with `rst_n`=1.
- Reset asserted mid-write: the write is lost and the register reads 0.

## Structure
- `riscv_pkg` holds `XLEN`, `NREGS`, `REG_IDX_W` and the `ZERO_REG` default, shared with the decoder and hazard unit.
- Sub-module `reg_scoreboard`: `NREGS`-bit busy vector, with set/clear/flush priority logic, `busy_vec` output, and per-port `r_busy` lookup including the clear-bypass.
- The top level holds the data array, the bypass muxes, and generate loops over `NRD`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run after writing x5=0xDEADBEEF → `r_data` for x5 is 0 and `busy_vec`=0 immediately, with no clock needed.
- **Zero register:** write x0=0x1234 with `sb_set_en` on x0 → x0 reads 0 and never shows busy. Repeat with `ZERO_REG`=0 → reads 0x1234 and busy is set.
- **Bypass:** `w_en`, x7, 0xA5A5A5A5 with `r_indx` port1=7 in the same cycle → port1 returns 0xA5A5A5A5 that cycle and the array holds it the next cycle. Ports not reading x7 are unaffected.
- **Scoreboard lifecycle:** `sb_set_en` x3 → `r_busy` for x3 is 1 next cycle. Write x3 → `r_busy` drops in the write cycle and stays 0.
- **Set beats clear:** same-cycle `sb_set_en` x9 and `w_en` x9=0x55 → x9 reads 0x55 and is still busy afterwards.
- **Flush:** busy x1, x2, x4, then `sb_flush` with `sb_set_en` x6 → `busy_vec`=only bit 6. Run with `NRD`=4 and `NREGS`=16, checking all ports on random traffic against a reference model.

Source files
------------

// File: rtl/riscv_pkg.sv
// Core-wide architectural constants shared by the register file, decoder and hazard unit.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);
    localparam bit ZERO_REG  = 1'b1;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits with flush/set/clear priority and per-port busy lookup.
module reg_scoreboard #(
    parameter int NREGS    = riscv_pkg::NREGS,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = riscv_pkg::ZERO_REG,
    parameter int IDX_W    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*IDX_W-1:0] r_indx,
    input  logic                 w_en,
    input  logic [IDX_W-1:0]     w_indx,
    input  logic                 sb_set_en,
    input  logic [IDX_W-1:0]     sb_set_indx,
    input  logic                 sb_flush,
    output logic [NRD-1:0]       r_busy,
    output logic [NREGS-1:0]     busy_vec
);
    import riscv_pkg::*;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // A new producer always wins: the set is applied last, over both flush and retire-clear.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NREGS; i++) begin
            if (sb_flush)
                busy_nxt[i] = 1'b0;
            else if (w_en && (w_indx == IDX_W'(i)))
                busy_nxt[i] = 1'b0;
            if (sb_set_en && (sb_set_indx == IDX_W'(i)))
                busy_nxt[i] = 1'b1;
        end
        if (ZERO_REG)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [IDX_W-1:0] idx;
        assign idx       = r_indx[k*IDX_W +: IDX_W];
        assign r_busy[k] = busy[idx] && !(w_en && (w_indx == idx));
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with write-to-read bypass and pending-write scoreboard.
module reg_file_sb #(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NREGS    = riscv_pkg::NREGS,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = riscv_pkg::ZERO_REG,
    parameter int IDX_W    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*IDX_W-1:0] r_indx,
    output logic [NRD*XLEN-1:0]  r_data,
    output logic [NRD-1:0]       r_busy,
    input  logic                 w_en,
    input  logic [IDX_W-1:0]     w_indx,
    input  logic [XLEN-1:0]      w_data,
    input  logic                 sb_set_en,
    input  logic [IDX_W-1:0]     sb_set_indx,
    output logic [NREGS-1:0]     busy_vec,
    input  logic                 sb_flush
);
    import riscv_pkg::*;

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_ok;

    assign wr_ok = w_en && !(ZERO_REG && (w_indx == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[w_indx] <= w_data;
        end
    end

    // Bypass is gated by reset so a write in flight during reset never leaks to the read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  rd;

        assign idx = r_indx[k*IDX_W +: IDX_W];

        always_comb begin
            rd = mem[idx];
            if (!rst_n || (ZERO_REG && (idx == '0)))
                rd = '0;
            else if (wr_ok && (w_indx == idx))
                rd = w_data;
        end

        assign r_data[k*XLEN +: XLEN] = rd;
    end

    reg_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .IDX_W    (IDX_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .r_indx      (r_indx),
        .w_en        (w_en),
        .w_indx      (w_indx),
        .sb_set_en   (sb_set_en),
        .sb_set_indx (sb_set_indx),
        .sb_flush    (sb_flush),
        .r_busy      (r_busy),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table plus corner sequences on a default instance, and a model-checked 4-port/16-reg instance.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: XLEN=32, NREGS=32, NRD=2, ZERO_REG=1
    logic [9:0]  a_r_indx;
    logic [63:0] a_r_data;
    logic [1:0]  a_r_busy;
    logic        a_w_en;
    logic [4:0]  a_w_indx;
    logic [31:0] a_w_data;
    logic        a_set_en;
    logic [4:0]  a_set_indx;
    logic [31:0] a_busy_vec;
    logic        a_flush;

    // Instance B: XLEN=32, NREGS=16, NRD=4, ZERO_REG=0
    logic [15:0]  b_r_indx;
    logic [127:0] b_r_data;
    logic [3:0]   b_r_busy;
    logic         b_w_en;
    logic [3:0]   b_w_indx;
    logic [31:0]  b_w_data;
    logic         b_set_en;
    logic [3:0]   b_set_indx;
    logic [15:0]  b_busy_vec;
    logic         b_flush;

    reg_file_sb dut_a (
        .clk (clk), .rst_n (rst_n),
        .r_indx (a_r_indx), .r_data (a_r_data), .r_busy (a_r_busy),
        .w_en (a_w_en), .w_indx (a_w_indx), .w_data (a_w_data),
        .sb_set_en (a_set_en), .sb_set_indx (a_set_indx),
        .busy_vec (a_busy_vec), .sb_flush (a_flush)
    );

    reg_file_sb #(.XLEN(32), .NREGS(16), .NRD(4), .ZERO_REG(1'b0)) dut_b (
        .clk (clk), .rst_n (rst_n),
        .r_indx (b_r_indx), .r_data (b_r_data), .r_busy (b_r_busy),
        .w_en (b_w_en), .w_indx (b_w_indx), .w_data (b_w_data),
        .sb_set_en (b_set_en), .sb_set_indx (b_set_indx),
        .busy_vec (b_busy_vec), .sb_flush (b_flush)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic        se;
        logic [4:0]  si;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] bv;
    } vec_t;

    vec_t tbl[15];

    task automatic a_step(input int n, input vec_t v);
        @(negedge clk);
        a_w_en = v.we; a_w_indx = v.wi; a_w_data = v.wd;
        a_set_en = v.se; a_set_indx = v.si; a_flush = v.fl;
        a_r_indx = {v.r1, v.r0};
        #1;
        chk($sformatf("row%0d_d0", n), a_r_data[31:0], v.d0);
        chk($sformatf("row%0d_d1", n), a_r_data[63:32], v.d1);
        chk($sformatf("row%0d_b0", n), {31'b0, a_r_busy[0]}, {31'b0, v.b0});
        chk($sformatf("row%0d_b1", n), {31'b0, a_r_busy[1]}, {31'b0, v.b1});
        chk($sformatf("row%0d_bv", n), a_busy_vec, v.bv);
    endtask

    // Reference model for instance B
    logic [31:0] m_mem [16];
    logic [15:0] m_busy;

    task automatic b_step(input logic we, input logic [3:0] wi, input logic [31:0] wd,
                          input logic se, input logic [3:0] si, input logic fl,
                          input logic [15:0] ri);
        logic [3:0]  idx;
        logic [31:0] exp_d;
        logic        exp_b;
        @(negedge clk);
        b_w_en = we; b_w_indx = wi; b_w_data = wd;
        b_set_en = se; b_set_indx = si; b_flush = fl;
        b_r_indx = ri;
        #1;
        for (int k = 0; k < 4; k++) begin
            idx   = ri[k*4 +: 4];
            exp_d = (we && wi == idx) ? wd : m_mem[idx];
            exp_b = m_busy[idx] && !(we && wi == idx);
            chk($sformatf("b_rd%0d", k), b_r_data[k*32 +: 32], exp_d);
            chk($sformatf("b_busy%0d", k), {31'b0, b_r_busy[k]}, {31'b0, exp_b});
        end
        chk("b_busy_vec", {16'b0, b_busy_vec}, {16'b0, m_busy});
        if (we) m_mem[wi] = wd;
        if (fl) m_busy = '0;
        else if (we) m_busy[wi] = 1'b0;
        if (se) m_busy[si] = 1'b1;
    endtask

    initial begin
        //             we   wi     wd            se   si    fl   r0    r1    d0            d1            b0   b1   bv
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd5, 32'h0,        32'h0,        1'b1, 1'b0, 32'h8};
        tbl[2]  = '{1'b1, 5'd3, 32'h11110003, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h11110003, 32'h11110003, 1'b0, 1'b0, 32'h8};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h11110003, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd2, 5'd7, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 32'hA5A5A5A5, 32'h11110003, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 5'd9, 32'h55,       1'b1, 5'd9, 1'b0, 5'd9, 5'd1, 32'h55,       32'h0,        1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h55,       32'h55,       1'b1, 1'b1, 32'h200};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd1, 5'd9, 32'h0,        32'h55,       1'b0, 1'b1, 32'h200};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd1, 5'd2, 32'h0,        32'h0,        1'b1, 1'b0, 32'h202};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd2, 5'd4, 32'h0,        32'h0,        1'b1, 1'b0, 32'h206};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 1'b1, 5'd4, 5'd6, 32'h0,        32'h0,        1'b1, 1'b0, 32'h216};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd1, 5'd6, 32'h0,        32'h0,        1'b0, 1'b1, 32'h40};

        rst_n = 1'b0;
        a_w_en = 0; a_w_indx = 0; a_w_data = 0; a_set_en = 0; a_set_indx = 0; a_flush = 0; a_r_indx = 0;
        b_w_en = 0; b_w_indx = 0; b_w_data = 0; b_set_en = 0; b_set_indx = 0; b_flush = 0; b_r_indx = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_busy = '0;

        repeat (2) @(negedge clk);
        a_r_indx = {5'd3, 5'd7};
        #1;
        chk("rst_a_d0", a_r_data[31:0], 32'h0);
        chk("rst_a_d1", a_r_data[63:32], 32'h0);
        chk("rst_a_bv", a_busy_vec, 32'h0);
        chk("rst_b_bv", {16'b0, b_busy_vec}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            a_step(i, tbl[i]);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        a_set_en = 0; a_flush = 0;
        a_w_en = 1; a_w_indx = 5; a_w_data = 32'hDEADBEEF; a_r_indx = {5'd5, 5'd5};
        @(negedge clk);
        a_w_en = 0; a_set_en = 1; a_set_indx = 5;
        #1;
        chk("x5_written", a_r_data[31:0], 32'hDEADBEEF);
        @(negedge clk);
        a_set_en = 0;
        #1;
        chk("x5_busy_bv", a_busy_vec, 32'h60);
        chk("x5_busy_port", {31'b0, a_r_busy[1]}, 32'h1);
        #2;
        a_w_en = 1; a_w_indx = 5; a_w_data = 32'h77;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_d0", a_r_data[31:0], 32'h0);
        chk("rst_mid_d1", a_r_data[63:32], 32'h0);
        chk("rst_mid_bv", a_busy_vec, 32'h0);
        chk("rst_mid_busy", {30'b0, a_r_busy}, 32'h0);
        @(negedge clk);
        a_w_en = 0;
        #1;
        chk("rst_lost_write", a_r_data[31:0], 32'h0);
        a_w_en = 1;
        rst_n = 1'b1;
        @(negedge clk);
        a_w_en = 0;
        #1;
        chk("first_write_after_rst", a_r_data[31:0], 32'h77);
        chk("after_rst_bv", a_busy_vec, 32'h0);

        // Instance B: x0 is an ordinary register when ZERO_REG=0
        b_step(1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 1'b0, 16'h0000);
        b_step(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b0, 16'h0000);
        chk("b_x0_data", b_r_data[31:0], 32'h1234);
        chk("b_x0_busy", {31'b0, b_r_busy[0]}, 32'h1);

        // Flush with surviving set on instance B
        b_step(1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b0, 16'h4321);
        b_step(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 1'b1, 16'h6210);
        b_step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 16'h6210);
        chk("b_flush_bv", {16'b0, b_busy_vec}, 32'h40);

        for (int n = 0; n < 300; n++) begin
            b_step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                   1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 19) == 0), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
